// File: rtl/cdc_4phase_responder.sv
`default_nettype none
// ============================================================================
//  Module   : cdc_4phase_responder
//  Purpose  : Receives a 4-phase request from a remote clock domain, presents
//             it to a local valid/ready target, collects the target's
//             response, and returns it over an outbound 4-phase handshake.
//  Revision : 1.0  initial release
// ============================================================================
module cdc_4phase_responder #(
  parameter int REQ_W       = 41,
  parameter int RSP_W       = 34,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             async_req_i,
  output logic             async_ack_o,
  input  logic [REQ_W-1:0] async_req_data_i,
  output logic [REQ_W-1:0] req_o,
  output logic             req_valid_o,
  input  logic             req_ready_i,
  input  logic [RSP_W-1:0] rsp_data_i,
  input  logic             rsp_valid_i,
  output logic             rsp_ready_o,
  output logic             async_rsp_req_o,
  input  logic             async_rsp_ack_i,
  output logic [RSP_W-1:0] async_rsp_data_o,
  output logic             busy_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRESENT  = 3'd1,
    S_REQ_REL  = 3'd2,
    S_WAIT_RSP = 3'd3,
    S_RSP_SEND = 3'd4,
    S_RSP_REL  = 3'd5
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_req_sync;
  logic [SYNC_STAGES-1:0] r_ack_sync;
  logic [REQ_W-1:0]       r_req_q;
  logic [RSP_W-1:0]       r_rsp_data;
  logic                   r_ack;
  logic                   r_rsp_req;

  logic                   w_req_s;
  logic                   w_ack_s;
  logic                   w_cap_req;
  logic                   w_cap_rsp;
  logic                   w_ack_nxt;
  logic                   w_rsp_req_nxt;
  logic                   w_req_valid;
  logic                   w_rsp_ready;

  // Synchronizer chains: the raw async inputs are consumed only here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_req_sync <= '0;
      r_ack_sync <= '0;
    end else begin
      r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], async_req_i};
      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], async_rsp_ack_i};
    end
  end

  assign w_req_s = r_req_sync[SYNC_STAGES-1];
  assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

  // State, handshake flops and payload captures.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_req_q    <= '0;
      r_rsp_data <= '0;
      r_ack      <= 1'b0;
      r_rsp_req  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ack     <= w_ack_nxt;
      r_rsp_req <= w_rsp_req_nxt;
      if (w_cap_req) r_req_q    <= async_req_data_i;
      if (w_cap_rsp) r_rsp_data <= rsp_data_i;
    end
  end

  // Next-state and handshake decode; PRESENT deliberately ignores req_s so an
  // accepted-but-unserviced request is never lost if the remote side drops it.
  always_comb begin
    w_state_nxt   = r_state;
    w_cap_req     = 1'b0;
    w_cap_rsp     = 1'b0;
    w_ack_nxt     = r_ack;
    w_rsp_req_nxt = r_rsp_req;
    w_req_valid   = 1'b0;
    w_rsp_ready   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req_s) begin
          w_cap_req   = 1'b1;
          w_state_nxt = S_PRESENT;
        end
      end
      S_PRESENT: begin
        w_req_valid = 1'b1;
        if (req_ready_i) begin
          w_ack_nxt   = 1'b1;
          w_state_nxt = S_REQ_REL;
        end
      end
      S_REQ_REL: begin
        if (!w_req_s) begin
          w_ack_nxt   = 1'b0;
          w_state_nxt = S_WAIT_RSP;
        end
      end
      S_WAIT_RSP: begin
        w_rsp_ready = 1'b1;
        if (rsp_valid_i) begin
          w_cap_rsp     = 1'b1;
          w_rsp_req_nxt = 1'b1;
          w_state_nxt   = S_RSP_SEND;
        end
      end
      S_RSP_SEND: begin
        if (w_ack_s) begin
          w_rsp_req_nxt = 1'b0;
          w_state_nxt   = S_RSP_REL;
        end
      end
      S_RSP_REL: begin
        if (!w_ack_s) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_ack_nxt     = 1'b0;
        w_rsp_req_nxt = 1'b0;
        w_state_nxt   = S_IDLE;
      end
    endcase
  end

  assign req_o            = r_req_q;
  assign req_valid_o      = w_req_valid;
  assign rsp_ready_o      = w_rsp_ready;
  assign async_ack_o      = r_ack;
  assign async_rsp_req_o  = r_rsp_req;
  assign async_rsp_data_o = r_rsp_data;
  assign busy_o           = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cdc_4phase_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cdc_4phase_responder
//  Purpose  : Directed self-checking bench for cdc_4phase_responder; the bench
//             plays both the remote 4-phase peer and the local target.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cdc_4phase_responder;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b1;
  logic        areq      = 1'b0;
  logic [40:0] adata     = '0;
  logic        ready     = 1'b0;
  logic [33:0] rsp_data  = '0;
  logic        rsp_valid = 1'b0;
  logic        rack      = 1'b0;

  logic        aack;
  logic [40:0] req_o;
  logic        req_valid;
  logic        rsp_ready;
  logic        rreq;
  logic [33:0] rdata;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  cdc_4phase_responder #(
    .REQ_W      (41),
    .RSP_W      (34),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .async_req_i     (areq),
    .async_ack_o     (aack),
    .async_req_data_i(adata),
    .req_o           (req_o),
    .req_valid_o     (req_valid),
    .req_ready_i     (ready),
    .rsp_data_i      (rsp_data),
    .rsp_valid_i     (rsp_valid),
    .rsp_ready_o     (rsp_ready),
    .async_rsp_req_o (rreq),
    .async_rsp_ack_i (rack),
    .async_rsp_data_o(rdata),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sel_sig(input int sel);
    case (sel)
      0:       return aack;
      1:       return rreq;
      2:       return busy;
      default: return req_valid;
    endcase
  endfunction

  // Bounded wait for a 1-bit output to reach a level; timeout shows up as a miscompare.
  task automatic wait_sig(input int sel, input logic val, input string tag);
    int n;
    n = 0;
    while (sel_sig(sel) !== val && n < 100) begin
      tick();
      n++;
    end
    chk(tag, {63'd0, sel_sig(sel)}, {63'd0, val});
  endtask

  // Complete request/response round trip with the local target always ready.
  task automatic do_txn(input logic [40:0] d, input logic [33:0] r, input string tag);
    ready = 1'b1;
    adata = d;
    areq  = 1'b1;
    wait_sig(3, 1'b1, {tag, "_valid"});
    chk({tag, "_req_o"}, {23'd0, req_o}, {23'd0, d});
    tick();
    chk({tag, "_ack1"}, {63'd0, aack}, 64'd1);
    areq = 1'b0;
    wait_sig(0, 1'b0, {tag, "_ack0"});
    rsp_valid = 1'b1;
    rsp_data  = r;
    tick();
    rsp_valid = 1'b0;
    chk({tag, "_rreq1"}, {63'd0, rreq}, 64'd1);
    chk({tag, "_rdata"}, {30'd0, rdata}, {30'd0, r});
    rack = 1'b1;
    wait_sig(1, 1'b0, {tag, "_rreq0"});
    rack = 1'b0;
    wait_sig(2, 1'b0, {tag, "_idle"});
  endtask

  initial begin
    logic [40:0] d1, d2, d3, d4, d5, d6;
    logic [33:0] r1, r2, r3, r4, r5, r6;
    d1 = 41'h0ADEADBEEF2; r1 = 34'h123456780;
    d2 = 41'h1F0F0F0F0F0; r2 = 34'h2AAAA5555;
    d3 = 41'h0123456789A; r3 = 34'h0CAFEF00D;
    d4 = 41'h1FEDCBA9876; r4 = 34'h3BADC0DE5;
    d5 = 41'h00000000001; r5 = 34'h3FFFFFFFF;
    d6 = 41'h15555555555; r6 = 34'h155555555;

    // Reset values
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ack",     {63'd0, aack},      64'd0);
    chk("rst_rreq",    {63'd0, rreq},      64'd0);
    chk("rst_rdata",   {30'd0, rdata},     64'd0);
    chk("rst_valid",   {63'd0, req_valid}, 64'd0);
    chk("rst_rready",  {63'd0, rsp_ready}, 64'd0);
    chk("rst_busy",    {63'd0, busy},      64'd0);
    chk("rst_req_o",   {23'd0, req_o},     64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single transaction with latency check
    ready = 1'b1;
    adata = d1;
    areq  = 1'b1;
    tick();
    tick();
    chk("t1_lat2_valid", {63'd0, req_valid}, 64'd0);
    tick();
    chk("t1_lat3_valid", {63'd0, req_valid}, 64'd1);
    chk("t1_req_o",      {23'd0, req_o},     {23'd0, d1});
    chk("t1_busy",       {63'd0, busy},      64'd1);
    tick();
    chk("t1_ack1",       {63'd0, aack},      64'd1);
    chk("t1_valid0",     {63'd0, req_valid}, 64'd0);
    areq = 1'b0;
    wait_sig(0, 1'b0, "t1_ack0");
    chk("t1_rready",     {63'd0, rsp_ready}, 64'd1);
    rsp_valid = 1'b1;
    rsp_data  = r1;
    tick();
    rsp_valid = 1'b0;
    chk("t1_rreq1",      {63'd0, rreq},      64'd1);
    chk("t1_rdata",      {30'd0, rdata},     {30'd0, r1});
    chk("t1_rready0",    {63'd0, rsp_ready}, 64'd0);
    rack = 1'b1;
    wait_sig(1, 1'b0, "t1_rreq0");
    chk("t1_rdata_hold", {30'd0, rdata},     {30'd0, r1});
    rack = 1'b0;
    wait_sig(2, 1'b0, "t1_idle");

    // Spurious response while idle
    rsp_valid = 1'b1;
    rsp_data  = 34'h111111111;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sp_idle_rready", {63'd0, rsp_ready}, 64'd0);
      chk("sp_idle_rreq",   {63'd0, rreq},      64'd0);
      chk("sp_idle_busy",   {63'd0, busy},      64'd0);
    end
    rsp_valid = 1'b0;

    // Back-pressure, remote drops request at cycle 5, spurious response in PRESENT
    ready = 1'b0;
    adata = d2;
    areq  = 1'b1;
    wait_sig(3, 1'b1, "bp_valid");
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_valid",  {63'd0, req_valid}, 64'd1);
      chk("bp_hold_req_o",  {23'd0, req_o},     {23'd0, d2});
      chk("bp_hold_ack",    {63'd0, aack},      64'd0);
      chk("bp_sp_rready",   {63'd0, rsp_ready}, 64'd0);
      chk("bp_sp_rreq",     {63'd0, rreq},      64'd0);
      if (i == 5) areq = 1'b0;
      rsp_valid = (i == 3 || i == 4);
      tick();
    end
    rsp_valid = 1'b0;
    chk("bp_still_valid", {63'd0, req_valid}, 64'd1);
    ready = 1'b1;
    tick();
    chk("bp_ack1", {63'd0, aack}, 64'd1);
    wait_sig(0, 1'b0, "bp_ack0");
    rsp_valid = 1'b1;
    rsp_data  = r2;
    tick();
    rsp_valid = 1'b0;
    chk("bp_rreq1", {63'd0, rreq}, 64'd1);

    // Slow remote acknowledge
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("slow_rreq",  {63'd0, rreq},  64'd1);
      chk("slow_rdata", {30'd0, rdata}, {30'd0, r2});
      chk("slow_busy",  {63'd0, busy},  64'd1);
    end
    rack = 1'b1;
    wait_sig(1, 1'b0, "slow_rreq0");
    rack = 1'b0;
    wait_sig(2, 1'b0, "slow_idle");

    // Back-to-back requests
    ready = 1'b1;
    adata = d3;
    areq  = 1'b1;
    wait_sig(3, 1'b1, "b2b_valid1");
    chk("b2b_req_o1", {23'd0, req_o}, {23'd0, d3});
    tick();
    chk("b2b_ack1", {63'd0, aack}, 64'd1);
    areq = 1'b0;
    wait_sig(0, 1'b0, "b2b_ack0");
    adata = d4;
    areq  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("b2b_wait_valid", {63'd0, req_valid}, 64'd0);
      chk("b2b_wait_busy",  {63'd0, busy},      64'd1);
    end
    rsp_valid = 1'b1;
    rsp_data  = r3;
    tick();
    rsp_valid = 1'b0;
    chk("b2b_rdata1", {30'd0, rdata}, {30'd0, r3});
    rack = 1'b1;
    wait_sig(1, 1'b0, "b2b_rreq0_1");
    chk("b2b_rel_valid", {63'd0, req_valid}, 64'd0);
    rack = 1'b0;
    wait_sig(3, 1'b1, "b2b_valid2");
    chk("b2b_req_o2", {23'd0, req_o}, {23'd0, d4});
    tick();
    chk("b2b_ack2", {63'd0, aack}, 64'd1);
    areq = 1'b0;
    wait_sig(0, 1'b0, "b2b_ack0_2");
    rsp_valid = 1'b1;
    rsp_data  = r4;
    tick();
    rsp_valid = 1'b0;
    chk("b2b_rreq2",  {63'd0, rreq},  64'd1);
    chk("b2b_rdata2", {30'd0, rdata}, {30'd0, r4});
    rack = 1'b1;
    wait_sig(1, 1'b0, "b2b_rreq0_2");
    rack = 1'b0;
    wait_sig(2, 1'b0, "b2b_idle");
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("b2b_no_dup", {63'd0, busy}, 64'd0);
    end

    // Reset asserted while in RSP_SEND
    ready = 1'b1;
    adata = d5;
    areq  = 1'b1;
    wait_sig(3, 1'b1, "rs_valid");
    tick();
    areq = 1'b0;
    wait_sig(0, 1'b0, "rs_ack0");
    rsp_valid = 1'b1;
    rsp_data  = r5;
    tick();
    rsp_valid = 1'b0;
    chk("rs_rreq1", {63'd0, rreq}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rs_rreq0",   {63'd0, rreq},      64'd0);
    chk("rs_busy0",   {63'd0, busy},      64'd0);
    chk("rs_rdata0",  {30'd0, rdata},     64'd0);
    chk("rs_ack0b",   {63'd0, aack},      64'd0);
    chk("rs_valid0",  {63'd0, req_valid}, 64'd0);
    chk("rs_req_o0",  {23'd0, req_o},     64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rs_post_idle", {63'd0, busy}, 64'd0);
    do_txn(d6, r6, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cdc_4phase_responder.md
CDC_4PHASE_RESPONDER -- requirements
Module: cdc_4phase_responder

Interface
REQ-001 Parameter REQ_W, default 41, width of the inbound request payload (addr 7 + data 32 + op 2).
REQ-002 Parameter RSP_W, default 34, width of the outbound response payload (data 32 + resp 2).
REQ-003 Parameter SYNC_STAGES, default 2, flop depth of each inbound synchronizer; legal values are 2 or more.
REQ-004 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 async_req_i  in  1  inbound 4-phase request from the remote domain.
REQ-007 async_ack_o  out  1  inbound 4-phase acknowledge, driven directly from a flop.
REQ-008 async_req_data_i  in  REQ_W  inbound payload, stable while async_req_i is high.
REQ-009 req_o  out  REQ_W  request to the local target.
REQ-010 req_valid_o  out  1  req_o valid.
REQ-011 req_ready_i  in  1  local target accepts req_o.
REQ-012 rsp_data_i  in  RSP_W  response from the local target.
REQ-013 rsp_valid_i  in  1  rsp_data_i valid.
REQ-014 rsp_ready_o  out  1  block accepts the response.
REQ-015 async_rsp_req_o  out  1  outbound 4-phase request, driven directly from a flop.
REQ-016 async_rsp_ack_i  in  1  outbound 4-phase acknowledge from the remote domain.
REQ-017 async_rsp_data_o  out  RSP_W  outbound payload, driven directly from a flop.
REQ-018 busy_o  out  1  high whenever the FSM is not in IDLE.

Function
REQ-019 async_req_i and async_rsp_ack_i SHALL each pass through a SYNC_STAGES-flop synchronizer (req_s, ack_s); no other logic SHALL use the raw signals.
REQ-020 FSM states SHALL be IDLE, PRESENT, REQ_REL, WAIT_RSP, RSP_SEND, RSP_REL; illegal encodings SHALL return to IDLE.
REQ-021 IDLE: if req_s=1, capture async_req_data_i into req_q and go to PRESENT; otherwise stay in IDLE.
REQ-022 PRESENT: req_valid_o=1 and req_o=req_q; on req_ready_i=1, set ack flop to 1 and go to REQ_REL.
REQ-023 PRESENT SHALL ignore req_s; a request is held until it is accepted, even if the remote side drops its request.
REQ-024 REQ_REL: hold ack=1; when req_s=0, clear ack to 0 and go to WAIT_RSP.
REQ-025 WAIT_RSP: rsp_ready_o=1; on rsp_valid_i=1, capture rsp_data_i into the response data flop, set the response request flop to 1, and go to RSP_SEND.
REQ-026 RSP_SEND: hold the request at 1; when ack_s=1, clear the request to 0 and go to RSP_REL.
REQ-027 RSP_REL: when ack_s=0, go to IDLE.
REQ-028 rsp_ready_o SHALL be 0 outside WAIT_RSP; rsp_valid_i SHALL be ignored there.
REQ-029 req_valid_o SHALL be 0 outside PRESENT; req_o SHALL always equal req_q.
REQ-030 async_rsp_data_o SHALL not change from entry to RSP_SEND until exit from RSP_REL.
REQ-031 Latency: req_valid_o rises SYNC_STAGES+1 clk_i edges after async_req_i rises, with no back-pressure.
REQ-032 Latency: async_ack_o rises on the edge after the req_valid_o/req_ready_i handshake.
REQ-033 Latency: async_rsp_req_o rises on the edge after the rsp_valid_i/rsp_ready_o handshake.
REQ-034 A new remote request arriving before return to IDLE SHALL wait in the synchronizer and be serviced from IDLE; it SHALL not be dropped or duplicated.
REQ-035 Exactly one response SHALL be sent per accepted request, in order.

Reset
REQ-036 While rst_ni=0, immediately and independent of clk_i: state=IDLE, both synchronizers=0, req_q=0, ack=0, response request=0, response data=0.
REQ-037 Consequently, during reset: async_ack_o=0, async_rsp_req_o=0, async_rsp_data_o=0, req_valid_o=0, rsp_ready_o=0, busy_o=0, req_o=0.
REQ-038 Reset asserted mid-transaction SHALL abort it with no outputs pending; the first post-reset action SHALL depend only on req_s.

Verification
REQ-039 Single transaction: data 0x0A_DEADBEEF_2, ready tied 1, rsp 0x1_2345678_0 (34 b) -> req_valid_o rises 3 edges after async_req_i with req_o=0x0ADEADBEEF2; one full 4-phase cycle out with async_rsp_data_o=0x123456780; returns to IDLE.
REQ-040 Back-pressure: req_ready_i=0 for 10 cycles and async_req_i dropped at cycle 5 -> req_valid_o held for all 10 cycles with stable req_o; async_ack_o stays 0 until the handshake.
REQ-041 Back-to-back: second request raised as soon as async_ack_o falls -> it is not presented until the first response's RSP_REL completes; two responses, in order.
REQ-042 Spurious response: rsp_valid_i pulsed in IDLE and PRESENT -> rsp_ready_o=0 and no async_rsp_req_o activity.
REQ-043 Reset in RSP_SEND with async_rsp_req_o=1 -> async_rsp_req_o and busy_o drop to 0 without a clock edge; after release, a new request completes normally.
REQ-044 Slow remote ack: async_rsp_ack_i delayed 50 cycles -> async_rsp_req_o and async_rsp_data_o held constant, busy_o=1 throughout.
